// File: rtl/dscope_acq_pkg.sv
// Shared types and constants for the dscope acquisition sweep scheduler.
package dscope_acq_pkg;

  localparam int NUM_VCHN_DFLT = 4;
  localparam int VCHN_W        = $clog2(NUM_VCHN_DFLT);
  localparam int OVR_W         = 16;
  // Cycles after o_complite falls before the reader's busy flag can be trusted.
  localparam int DRAIN_HOLD    = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    WAIT,
    NEXT,
    DONE,
    DRAIN
  } acq_state_e;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/acq_period_timer.sv
// Sweep period down-counter: ticks once every i_period cycles of i_run.
// i_period of zero disables the tick.
module acq_period_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic                i_run,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first, so no path leaves cnt_d unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_period;
    end else if (i_run) begin
      // Reload on the tick cycle, and also from 0 so a period written while disabled takes effect.
      if (cnt_q <= PERIOD_W'(1)) cnt_d = i_period;
      else                       cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_tick = i_run && (cnt_q == PERIOD_W'(1)) && (i_period != '0);

endmodule

// File: rtl/acq_sweep_sched.sv
// Acquisition sweep scheduler: walks every vchn, starts all capture buffers and gathers their done.
// Define ACQ_EXT_TRIG_EN to synchronise i_ext_trig and use its rising edge as a trigger source.
module acq_sweep_sched
  import dscope_acq_pkg::*;
#(
  parameter int NUM_VCHN = NUM_VCHN_DFLT,
  parameter int NUM_BUF  = 4,
  parameter int PERIOD_W = 24,
  parameter int TMO_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  input  logic [PERIOD_W-1:0]         i_period,
  input  logic                        i_soft_trig,
  input  logic                        i_ext_trig,
  input  logic [NUM_BUF-1:0]          i_cap_done,
  input  logic                        i_rd_busy,
  output logic [$clog2(NUM_VCHN)-1:0] o_wr_vchn,
  output logic                        o_cap_start,
  output logic                        o_complite,
  output logic                        o_busy,
  output logic                        o_timeout,
  output logic [OVR_W-1:0]            o_overrun_cnt
);

  localparam int VW      = $clog2(NUM_VCHN);
  localparam int DRAIN_W = $clog2(DRAIN_HOLD + 1);
  localparam logic [VW-1:0] LAST_VCHN = VW'(NUM_VCHN - 1);

  acq_state_e           state_q,     state_d;
  logic [VW-1:0]        vchn_q,      vchn_d;
  logic [NUM_BUF-1:0]   mask_q,      mask_d;
  logic [TMO_W-1:0]     tmo_q,       tmo_d;
  logic [DRAIN_W-1:0]   drain_q,     drain_d;
  logic                 timeout_q,   timeout_d;
  logic [OVR_W-1:0]     ovr_q,       ovr_d;
  logic                 cap_start_q, cap_start_d;
  logic                 complite_q,  complite_d;
  logic                 busy_q,      busy_d;

  logic tick;
  logic ext_rise;
  logic trig;

  // Held in load while IDLE, so the count always equals i_period on entry to ARM.
  acq_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (state_q == IDLE),
    .i_run    (state_q == ARM),
    .i_period (i_period),
    .o_tick   (tick)
  );

`ifdef ACQ_EXT_TRIG_EN
  // Two synchroniser stages plus one history stage for the rising-edge detect.
  logic [2:0] ext_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_sync_q <= '0;
    else        ext_sync_q <= {ext_sync_q[1:0], i_ext_trig};
  end

  assign ext_rise = ext_sync_q[1] & ~ext_sync_q[2];
`else
  logic unused_ext_trig;
  assign unused_ext_trig = i_ext_trig;
  assign ext_rise        = 1'b0;
`endif

  assign trig = tick | i_soft_trig | ext_rise;

  always_comb begin
    state_d   = state_q;
    vchn_d    = vchn_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    ovr_d     = ovr_q;

    // Any trigger that cannot start a sweep right now is dropped and counted.
    if (trig && (state_q != ARM)) ovr_d = sat_inc(ovr_q);

    unique case (state_q)
      IDLE: begin
        if (i_enable) state_d = ARM;
      end
      ARM: begin
        if (trig) begin
          state_d   = START;
          vchn_d    = '0;
          timeout_d = 1'b0;
        end else if (!i_enable) begin
          state_d = IDLE;
        end
      end
      START: begin
        mask_d  = '0;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        mask_d = mask_q | i_cap_done;
        tmo_d  = tmo_q + TMO_W'(1);
        if (&mask_d) begin
          state_d = NEXT;
        end else if (&tmo_d) begin
          timeout_d = 1'b1;
          state_d   = NEXT;
        end
      end
      NEXT: begin
        if (vchn_q == LAST_VCHN) begin
          state_d = DONE;
        end else begin
          vchn_d  = vchn_q + VW'(1);
          state_d = START;
        end
      end
      DONE: begin
        // o_complite is already low here, so this cycle counts toward the hold.
        drain_d = DRAIN_W'(1);
        state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q < DRAIN_W'(DRAIN_HOLD)) begin
          drain_d = drain_q + DRAIN_W'(1);
        end else if (!i_rd_busy) begin
          state_d = i_enable ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    cap_start_d = (state_d == START);
    complite_d  = (state_d inside {START, WAIT, NEXT});
    busy_d      = !(state_d inside {IDLE, ARM});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vchn_q      <= '0;
      mask_q      <= '0;
      tmo_q       <= '0;
      drain_q     <= '0;
      timeout_q   <= 1'b0;
      ovr_q       <= '0;
      cap_start_q <= 1'b0;
      complite_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vchn_q      <= vchn_d;
      mask_q      <= mask_d;
      tmo_q       <= tmo_d;
      drain_q     <= drain_d;
      timeout_q   <= timeout_d;
      ovr_q       <= ovr_d;
      cap_start_q <= cap_start_d;
      complite_q  <= complite_d;
      busy_q      <= busy_d;
    end
  end

  assign o_wr_vchn     = vchn_q;
  assign o_cap_start   = cap_start_q;
  assign o_complite    = complite_q;
  assign o_busy        = busy_q;
  assign o_timeout     = timeout_q;
  assign o_overrun_cnt = ovr_q;

endmodule

// File: tb/tb_acq_sweep_sched.sv
// Directed bench for acq_sweep_sched: period sweeps, timeout, overrun saturation,
// reader hold-off, async reset mid-sweep and the external trigger path.
module tb_acq_sweep_sched;
  import dscope_acq_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_enable;
  logic [23:0]       i_period;
  logic              i_soft_trig;
  logic              i_ext_trig;
  logic [3:0]        i_cap_done;
  logic              i_rd_busy;
  logic [VCHN_W-1:0] o_wr_vchn;
  logic              o_cap_start;
  logic              o_complite;
  logic              o_busy;
  logic              o_timeout;
  logic [OVR_W-1:0]  o_overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acq_sweep_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (i_enable),
    .i_period      (i_period),
    .i_soft_trig   (i_soft_trig),
    .i_ext_trig    (i_ext_trig),
    .i_cap_done    (i_cap_done),
    .i_rd_busy     (i_rd_busy),
    .o_wr_vchn     (o_wr_vchn),
    .o_cap_start   (o_cap_start),
    .o_complite    (o_complite),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_overrun_cnt (o_overrun_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the number of cycles until o_cap_start is seen, or -1 if the bound expires.
  task automatic wait_start(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (o_cap_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called in a START cycle: answers with mask m, d cycles later; returns in the cycle after.
  task automatic run_vchn(input int d, input logic [3:0] m);
    repeat (d) tick();
    i_cap_done = m;
    tick();
    i_cap_done = '0;
  endtask

  // Called in the START cycle of vchn0: fastest possible sweep, returns once back in ARM/IDLE.
  task automatic sweep_min(input string tag);
    int n;
    for (int v = 0; v < 4; v++) begin
      if (v > 0) begin
        wait_start(5, n);
        check({tag, "_gap"}, n, 1);
      end
      run_vchn(1, 4'hF);
    end
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    i_enable    = 1'b0;
    i_period    = '0;
    i_soft_trig = 1'b0;
    i_ext_trig  = 1'b0;
    i_cap_done  = '0;
    i_rd_busy   = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cap_start", o_cap_start, 0);
    check("rst_complite", o_complite, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_vchn", o_wr_vchn, 0);
    check("rst_overrun", o_overrun_cnt, 0);
    #2 rst_n = 1'b1;
    tick();

    // Sweep 1: periodic trigger, buffers answer 5 cycles after each start
    i_period = 24'd100;
    i_enable = 1'b1;
    wait_start(200, n);
    check("s1_first_latency", n, 101);
    for (int v = 0; v < 4; v++) begin
      check("s1_vchn", o_wr_vchn, v);
      check("s1_complite_hi", o_complite, 1);
      run_vchn(5, 4'hF);
      if (v < 3) begin
        wait_start(10, n);
        check("s1_vchn_gap", n, 1);
      end
    end
    check("s1_next_complite", o_complite, 1);
    tick();
    check("s1_done_complite", o_complite, 0);
    check("s1_done_busy", o_busy, 1);
    repeat (2) tick();
    check("s1_drain2_busy", o_busy, 1);
    tick();
    check("s1_arm_busy", o_busy, 0);

    // Sweep 2: next periodic start 100 ARM cycles later; then reader hold-off
    repeat (50) tick();
    i_period = 24'd1;
    wait_start(100, n);
    check("s2_period", n, 50);
    for (int v = 0; v < 4; v++) begin
      run_vchn(5, 4'hF);
      if (v < 3) wait_start(10, n);
    end
    i_rd_busy = 1'b1;
    tick();
    repeat (49) tick();
    check("s2_hold_busy", o_busy, 1);
    check("s2_hold_nostart", o_cap_start, 0);
    i_rd_busy = 1'b0;
    wait_start(10, n);
    check("s2_release_latency", n, 2);

    // Sweep 3: soft triggers dropped mid-sweep, done in START ignored, minimum vchn spacing
    i_period = '0;
    tick();
    i_soft_trig = 1'b1;
    repeat (3) tick();
    i_soft_trig = 1'b0;
    check("s3_overrun3", o_overrun_cnt, 3);
    i_cap_done = 4'hF;
    tick();
    i_cap_done = '0;
    wait_start(10, n);
    check("s3_vchn1", o_wr_vchn, 1);
    i_cap_done = 4'hF;
    tick();
    i_cap_done = '0;
    repeat (2) tick();
    check("s3_start_done_ignored", o_cap_start, 0);
    check("s3_still_complite", o_complite, 1);
    i_cap_done = 4'hF;
    tick();
    i_cap_done = '0;
    wait_start(10, n);
    check("s3_vchn2_gap", n, 1);
    run_vchn(1, 4'hF);
    wait_start(10, n);
    check("s3_min_gap", n, 1);
    check("s3_vchn3", o_wr_vchn, 3);
    run_vchn(1, 4'hF);
    repeat (4) tick();
    check("s3_idle_busy", o_busy, 0);
    wait_start(30, n);
    check("s3_no_extra_sweep", n, -1);
    check("s3_overrun_kept", o_overrun_cnt, 3);

    // Sweep 4: buffer 2 silent on vchn1 -> timeout; overrun driven to saturation meanwhile
    i_soft_trig = 1'b1;
    tick();
    i_soft_trig = 1'b0;
    check("s4_soft_latency", o_cap_start, 1);
    run_vchn(1, 4'hF);
    wait_start(5, n);
    check("s4_vchn1", o_wr_vchn, 1);
    tick();
    i_cap_done = 4'b1011;
    tick();
    i_cap_done  = '0;
    i_soft_trig = 1'b1;
    repeat (65531) tick();
    check("s4_overrun_fffe", o_overrun_cnt, 16'hFFFE);
    repeat (2) tick();
    check("s4_timeout_boundary", o_timeout, 0);
    check("s4_overrun_ffff", o_overrun_cnt, 16'hFFFF);
    tick();
    i_soft_trig = 1'b0;
    check("s4_timeout_set", o_timeout, 1);
    check("s4_overrun_sat", o_overrun_cnt, 16'hFFFF);
    wait_start(5, n);
    check("s4_after_tmo_gap", n, 1);
    check("s4_vchn2", o_wr_vchn, 2);
    run_vchn(1, 4'hF);
    wait_start(5, n);
    run_vchn(1, 4'hF);
    repeat (4) tick();
    check("s4_timeout_sticky", o_timeout, 1);

    // Sweep 5: timeout cleared by next trigger; async reset during WAIT of vchn2
    i_soft_trig = 1'b1;
    tick();
    i_soft_trig = 1'b0;
    check("s5_timeout_cleared", o_timeout, 0);
    run_vchn(1, 4'hF);
    wait_start(5, n);
    run_vchn(1, 4'hF);
    wait_start(5, n);
    check("s5_vchn2", o_wr_vchn, 2);
    repeat (2) tick();
    check("s5_pre_rst_complite", o_complite, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_complite", o_complite, 0);
    check("s5_rst_busy", o_busy, 0);
    check("s5_rst_vchn", o_wr_vchn, 0);
    check("s5_rst_overrun", o_overrun_cnt, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    i_soft_trig = 1'b1;
    tick();
    i_soft_trig = 1'b0;
    check("s5_restart", o_cap_start, 1);
    check("s5_restart_vchn", o_wr_vchn, 0);

    // Sweep 6: enable dropped mid-sweep -> completes, then IDLE
    i_enable = 1'b0;
    sweep_min("s6");
    check("s6_idle_busy", o_busy, 0);
    i_soft_trig = 1'b1;
    tick();
    i_soft_trig = 1'b0;
    wait_start(10, n);
    check("s6_idle_no_start", n, -1);
    check("s6_idle_overrun", o_overrun_cnt, 1);

    // External trigger path
    i_enable = 1'b1;
    tick();
    #3 i_ext_trig = 1'b1;
    tick();
    tick();
    i_ext_trig = 1'b0;
`ifdef ACQ_EXT_TRIG_EN
    wait_start(10, n);
    check("ext_latency", ((n + 2) inside {[3:4]}), 1);
    sweep_min("ext");
`else
    wait_start(20, n);
    check("ext_ignored", n, -1);
`endif
    check("ext_overrun", o_overrun_cnt, 1);

    // In ARM a trigger wins over i_enable=0
    i_enable    = 1'b0;
    i_soft_trig = 1'b1;
    tick();
    i_soft_trig = 1'b0;
    check("arm_trig_wins", o_cap_start, 1);
    sweep_min("s7");
    check("s7_idle_busy", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
